// File: rtl/seq_divider8_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_divider8_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  function automatic int unsigned cnt_width(int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int unsigned CNT_W = cnt_width(DEFAULT_WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

endpackage

// File: rtl/seq_divider8_if.sv
// Start/done request interface between a controller and seq_divider8.
interface seq_divider8_if
  import seq_divider8_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );

endinterface

// File: rtl/seq_divider8_sub_cla.sv
// Combinational lookahead subtractor: diff = a - b computed as a + ~b + 1.
module sub_cla #(
  parameter int unsigned WIDTH = 9
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;
  logic [WIDTH:0]   carry;

  assign gen  = a & ~b;
  assign prop = a ^ ~b;

  // Each carry is a flat sum of generate terms gated by the propagate run below it.
  always_comb begin
    logic term;
    logic run;
    carry    = '0;
    carry[0] = 1'b1;
    for (int i = 0; i < int'(WIDTH); i++) begin
      term = gen[i];
      run  = prop[i];
      for (int j = i - 1; j >= 0; j--) begin
        term = term | (run & gen[j]);
        run  = run & prop[j];
      end
      carry[i+1] = term | (run & carry[0]);
    end
  end

  assign diff   = prop ^ carry[WIDTH-1:0];
  assign borrow = ~carry[WIDTH];

endmodule

// File: rtl/seq_divider8.sv
// Iterative restoring divider, one trial subtraction per clock, signed or unsigned.
// Optional SEQ_DIVIDER8_EARLY_EXIT_EN finishes in one cycle when |dividend| < |divisor|.
module seq_divider8
  import seq_divider8_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic           clk,
  input logic           rst,
  seq_divider8_if.slave bus
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  state_t           state_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH:0]   dvs_q;
  logic [WIDTH-1:0] quo_q;
  logic [CntW-1:0]  cnt_q;
  logic             q_neg_q, r_neg_q, ovf_pend_q;
  logic             busy_q, done_q, dbz_q, ovf_q;
  logic [WIDTH-1:0] quot_q, rmdr_q;

  logic             a_neg, b_neg;
  logic [WIDTH:0]   a_mag, b_mag;
  logic [WIDTH:0]   rem_sh, diff;
  logic             borrow;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic             unused_msbs;

  assign a_neg = bus.signed_op & bus.dividend[WIDTH-1];
  assign b_neg = bus.signed_op & bus.divisor[WIDTH-1];
  // Sign-extend before negating so the most negative value maps to its true magnitude.
  assign a_mag = a_neg ? -{bus.dividend[WIDTH-1], bus.dividend} : {1'b0, bus.dividend};
  assign b_mag = b_neg ? -{bus.divisor[WIDTH-1], bus.divisor} : {1'b0, bus.divisor};

  assign rem_sh = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};

  sub_cla #(
    .WIDTH(WIDTH + 1)
  ) u_sub (
    .a     (rem_sh),
    .b     (dvs_q),
    .diff  (diff),
    .borrow(borrow)
  );

  assign q_fix = q_neg_q ? -quo_q : quo_q;
  assign r_fix = r_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

  // Partial remainder stays below the divisor, so its top bit never matters after a step.
  assign unused_msbs = rem_q[WIDTH] ^ a_mag[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      dvs_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
      quot_q     <= '0;
      rmdr_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.divisor == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              quot_q  <= '1;
              rmdr_q  <= bus.dividend;
              dbz_q   <= 1'b1;
              ovf_q   <= 1'b0;
`ifdef SEQ_DIVIDER8_EARLY_EXIT_EN
            end else if (a_mag < b_mag) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              quot_q  <= '0;
              rmdr_q  <= bus.dividend;
              dbz_q   <= 1'b0;
              ovf_q   <= 1'b0;
`endif
            end else begin
              state_q    <= RUN;
              busy_q     <= 1'b1;
              quo_q      <= a_mag[WIDTH-1:0];
              dvs_q      <= b_mag;
              rem_q      <= '0;
              cnt_q      <= CntW'(WIDTH - 1);
              q_neg_q    <= a_neg ^ b_neg;
              r_neg_q    <= a_neg;
              ovf_pend_q <= a_neg & b_neg & (bus.divisor == '1) &
                            (bus.dividend == {1'b1, {(WIDTH - 1){1'b0}}});
            end
          end
        end
        RUN: begin
          if (borrow) begin
            rem_q <= rem_sh;
            quo_q <= {quo_q[WIDTH-2:0], 1'b0};
          end else begin
            rem_q <= diff;
            quo_q <= {quo_q[WIDTH-2:0], 1'b1};
          end
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          quot_q  <= q_fix;
          rmdr_q  <= r_fix;
          dbz_q   <= 1'b0;
          ovf_q   <= ovf_pend_q;
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rmdr_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;

endmodule
